multicycle_arith_unit: RTL
==========================

// Module: multicycle_arith_unit
// PURPOSE
//  Parametrised integer arithmetic unit: ADD, SUB, MUL, MULH, DIVU and REMU on WIDTH-bit operands.
//  ADD and SUB complete in 1 cycle. MUL/MULH/DIVU/REMU use iterative 1-bit-per-cycle datapaths.
//  Uses valid/ready handshakes on both sides. Sits beside the ALU; the execute stage stalls on in_ready/out_valid.
// PARAMETERS
//  WIDTH  32  operand and result width (>=4)
//  ID_W   4   width of the request tag, echoed unchanged on the result
// PORTS
//  clk         in   1      single clock, rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  in_valid    in   1      request present
//  in_ready    out  1      unit can accept a request
//  in_op       in   3      000 ADD, 001 SUB, 010 MUL(low), 011 MULH(unsigned high), 100 DIVU, 101 REMU
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  in_id       in   ID_W   request tag
//  out_valid   out  1      result present
//  out_ready   in   1      consumer accepts result
//  out_result  out  WIDTH  result
//  out_id      out  ID_W   tag of the request that produced this result
//  busy        out  1      state != IDLE
//  out_flags   out  2      [0] divide-by-zero, [1] illegal op (present only with ARITH_FLAGS_EN)
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0; out_result, out_id, counter and flags are 0; in_ready=1; busy=0.
//  FSM states: IDLE, MUL, DIV, DONE. in_ready=1 only in IDLE. Accept = in_valid & in_ready.
//  IDLE, accepting ADD/SUB: result is a+b or a-b mod 2^WIDTH, go to DONE. out_valid is high the next cycle (latency 1).
//  IDLE, accepting MUL/MULH: latch the operands, counter=0, go to MUL.
//   MUL does one shift-add per cycle over WIDTH cycles into a 2*WIDTH-bit product, then goes to DONE.
//   out_valid rises WIDTH+1 cycles after accept. MUL returns product[WIDTH-1:0]; MULH returns product[2W-1:W].
//  IDLE, accepting DIVU/REMU with b!=0: go to DIV. DIV is restoring division, one quotient bit per cycle, WIDTH cycles.
//   Latency WIDTH+1. DIVU returns the quotient; REMU returns the remainder.
//  b==0 on DIVU/REMU: skip DIV and go to DONE with latency 1. DIVU returns all-ones; REMU returns a.
//  Ops 110/111: latency 1, result 0.
//  Counter is $clog2(WIDTH)+1 bits. Leave MUL/DIV when counter==WIDTH-1; no wrap occurs.
//  DONE: out_valid=1. out_result and out_id stay stable until out_ready=1. On that cycle go to IDLE and clear out_valid.
//   No new request is accepted in the same cycle: throughput is 1 op per 2 cycles for ADD/SUB.
//  out_ready is ignored outside DONE. in_valid/in_op/in_a/in_b are ignored unless in_ready=1.
//  reset_n low at any time, including mid-MUL/DIV or DONE, drops the in-flight op and forces reset values immediately.
//  out_result/out_id hold their last value while out_valid=0 and are meaningful only while out_valid=1.
// CONFIGURATION
//  ARITH_FLAGS_EN defined: out_flags exists and is registered with the result; it is valid and stable with out_valid.
//   Its reset value is 0. dz=1 for DIVU/REMU with b==0; illegal=1 for ops 110/111.
//  ARITH_FLAGS_EN undefined: out_flags port and its logic are absent. Results are identical in both builds.
// STRUCTURE
//  Package arith_pkg: arith_op_e (3-bit enum), arith_state_e, arith_flags_t struct {illegal, dz}, OP_* constants.
//  Sub-module iter_muldiv_core: shared shift register and adder for the MUL/DIV iterations.
//   Interface: start, is_div, a, b; outputs done, hi, lo. The top level holds the FSM, handshakes and result mux.
// TESTING (WIDTH=32, ID_W=4)
//  1 ADD 0xFFFFFFFF+0x1, id=3 -> 0x00000000, out_id=3, out_valid 1 cycle after accept. SUB 5-7 -> 0xFFFFFFFE.
//  2 MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULH with the same operands -> 0xFFFFFFFE.
//    out_valid exactly 33 cycles after accept; in_ready=0 and busy=1 throughout.
//  3 DIVU 100/7 -> 14, REMU 100/7 -> 2, 33-cycle latency. DIVU 0x80000000/1 -> 0x80000000.
//  4 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, latency 1, out_flags=2'b01 (flags build).
//    Op 111 -> result 0, out_flags=2'b10.
//  5 Hold out_ready=0 for 10 cycles after out_valid with in_valid=1 -> result, out_id, out_valid stay stable; in_ready=0.
//    Next op accepted only after the out_ready handshake.
//  6 Assert reset_n=0 in MUL cycle 10 -> out_valid=0, busy=0, in_ready=1 without a clock edge.
//    After release, DIVU 9/3 -> 3 with correct latency.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types for the multicycle arithmetic unit
package arith_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_MULH = 3'b011,
        OP_DIVU = 3'b100,
        OP_REMU = 3'b101,
        OP_ILL6 = 3'b110,
        OP_ILL7 = 3'b111
    } arith_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } arith_state_e;

    typedef struct packed {
        logic illegal;
        logic dz;
    } arith_flags_t;

    // Ops whose answer lives in the high half of the core (product high / remainder)
    function automatic logic op_uses_hi(input arith_op_e op);
        return (op == OP_MULH) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// rtl/iter_muldiv_core.sv - shared shift register and adder for 1-bit-per-cycle multiply and restoring divide
module iter_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // hi_q: partial product high half / partial remainder
    // lo_q: multiplier shifting out / dividend shifting into quotient
    // m_q : multiplicand or divisor
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] m_q;
    logic             div_q;
    logic             run_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_cin;
    logic [WIDTH+1:0] add_sum;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // One adder serves both modes: add for multiply, subtract-with-borrow-out for divide
    always_comb begin
        add_x   = {1'b0, hi_q};
        add_y   = {1'b0, m_q};
        add_cin = 1'b0;
        if (div_q) begin
            add_x   = {hi_q, lo_q[WIDTH-1]};
            add_y   = ~{1'b0, m_q};
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, add_cin};
    end

    // Next iteration value; exposed on hi/lo so the top can capture on the final step edge
    always_comb begin
        hi_n = hi_q;
        lo_n = lo_q;
        if (div_q) begin
            if (add_sum[WIDTH+1]) begin
                hi_n = add_sum[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = add_x[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo_q[0]) begin
                {hi_n, lo_n} = {add_sum[WIDTH:0], lo_q[WIDTH-1:1]};
            end else begin
                {hi_n, lo_n} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    assign done = run_q && (cnt_q == LAST);
    assign hi   = hi_n;
    assign lo   = lo_n;

    // Load on start, then step once per cycle until the last bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            hi_q  <= '0;
            lo_q  <= is_div ? a : b;
            m_q   <= is_div ? b : a;
            div_q <= is_div;
            run_q <= 1'b1;
            cnt_q <= '0;
        end else if (run_q) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            run_q <= !done;
            cnt_q <= done ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_arith_unit.sv
// rtl/multicycle_arith_unit.sv - ADD/SUB/MUL/MULH/DIVU/REMU unit with valid/ready handshakes; optional ARITH_FLAGS_EN adds out_flags
module multicycle_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [ID_W-1:0]  in_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [ID_W-1:0]  out_id,
    output logic             busy
`ifdef ARITH_FLAGS_EN
    ,
    output logic [1:0]       out_flags
`endif
);

    arith_state_e     state;
    arith_state_e     next_state;
    arith_op_e        op_in;
    arith_op_e        op_q;
    logic [ID_W-1:0]  id_q;

    logic             core_start;
    logic             core_is_div;
    logic             core_done;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] iter_result;

    logic             quick_load;
    logic [WIDTH-1:0] quick_result;
`ifdef ARITH_FLAGS_EN
    arith_flags_t     quick_flags;
    arith_flags_t     flags_q;
`endif

    assign op_in = arith_op_e'(in_op);

    iter_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (core_start),
        .is_div  (core_is_div),
        .a       (in_a),
        .b       (in_b),
        .done    (core_done),
        .hi      (core_hi),
        .lo      (core_lo)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, core launch and single-cycle results
    always_comb begin
        next_state   = state;
        core_start   = 1'b0;
        core_is_div  = 1'b0;
        quick_load   = 1'b0;
        quick_result = '0;
`ifdef ARITH_FLAGS_EN
        quick_flags  = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    case (op_in)
                        OP_ADD: begin
                            quick_load   = 1'b1;
                            quick_result = in_a + in_b;
                            next_state   = ST_DONE;
                        end
                        OP_SUB: begin
                            quick_load   = 1'b1;
                            quick_result = in_a - in_b;
                            next_state   = ST_DONE;
                        end
                        OP_MUL, OP_MULH: begin
                            core_start = 1'b1;
                            next_state = ST_MUL;
                        end
                        OP_DIVU, OP_REMU: begin
                            if (in_b == '0) begin
                                // Divide by zero never enters the iterative path
                                quick_load   = 1'b1;
                                quick_result = (op_in == OP_DIVU) ? '1 : in_a;
`ifdef ARITH_FLAGS_EN
                                quick_flags.dz = 1'b1;
`endif
                                next_state   = ST_DONE;
                            end else begin
                                core_start  = 1'b1;
                                core_is_div = 1'b1;
                                next_state  = ST_DIV;
                            end
                        end
                        default: begin
                            quick_load = 1'b1;
`ifdef ARITH_FLAGS_EN
                            quick_flags.illegal = 1'b1;
`endif
                            next_state = ST_DONE;
                        end
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (core_done) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign iter_result = op_uses_hi(op_q) ? core_hi : core_lo;

    // Result registers only change when a result is produced, so they hold while out_valid is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_result <= '0;
            out_id     <= '0;
            op_q       <= OP_ADD;
            id_q       <= '0;
`ifdef ARITH_FLAGS_EN
            flags_q    <= '0;
`endif
        end else if (quick_load) begin
            out_result <= quick_result;
            out_id     <= in_id;
`ifdef ARITH_FLAGS_EN
            flags_q    <= quick_flags;
`endif
        end else if (core_start) begin
            op_q <= op_in;
            id_q <= in_id;
        end else if (((state == ST_MUL) || (state == ST_DIV)) && core_done) begin
            out_result <= iter_result;
            out_id     <= id_q;
`ifdef ARITH_FLAGS_EN
            flags_q    <= '0;
`endif
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
`ifdef ARITH_FLAGS_EN
    assign out_flags = flags_q;
`endif

endmodule
